fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer_pkg.sv | 29 ++
 rtl/fetch_sequencer_redirect_target_calc.sv | 36 +++
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer slice.
package fetch_sequencer_pkg;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // Redirect kinds as presented by branch/jump resolution.
   localparam logic [1:0] KIND_BRANCH = 2'b00;
   localparam logic [1:0] KIND_JUMP   = 2'b01;
   localparam logic [1:0] KIND_JR     = 2'b10;
   localparam logic [1:0] KIND_RSVD   = 2'b11;

   // Instruction field positions.
   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int JADDR_MSB = 25;
   localparam int JADDR_LSB = 0;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;

   // Opcode that parks the sequencer unless overridden.
   localparam logic [5:0] DEFAULT_HALT_OPCODE = 6'h3F;

endpackage

// File: rtl/fetch_sequencer_redirect_target_calc.sv
// Combinational redirect target computation for branch, jump and jr.
module redirect_target_calc
   import fetch_sequencer_pkg::*;
(
   input  logic [1:0]                   kind,
   input  logic [31:0]                  redirect_pc,
   input  logic [IMM_MSB:IMM_LSB]       imm16,
   input  logic [JADDR_MSB:JADDR_LSB]   jaddr,
   input  logic [31:0]                  reg_value,
   output logic [31:0]                  target,
   output logic                         reserved
);

   logic [31:0] seq_pc;
   logic [31:0] branch_offset;

   // Branches and jumps are relative to the instruction after the redirecting one.
   assign seq_pc        = redirect_pc + 32'd4;
   assign branch_offset = {{14{imm16[IMM_MSB]}}, imm16, 2'b00};

   // Select the target by kind; the reserved kind yields no usable target.
   always_comb begin
      target   = seq_pc;
      reserved = 1'b0;
      case (kind)
         KIND_BRANCH: target = seq_pc + branch_offset;
         KIND_JUMP:   target = {seq_pc[31:28], jaddr, 2'b00};
         KIND_JR:     target = reg_value;
         default: begin
            target   = seq_pc;
            reserved = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: fetches from a combinational instruction memory into a
// single-entry fetch register, applies redirects, and detects halt and faults.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int          MEM_BYTES   = 256,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic [31:0]  imem_pc,
   input  logic [31:0]  imem_instruction,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_instruction,
   output logic [31:0]  out_pc,
   input  logic         redirect_valid,
   input  logic [1:0]   redirect_kind,
   input  logic [31:0]  redirect_pc,
   input  logic [15:0]  redirect_imm16,
   input  logic [25:0]  redirect_jaddr,
   input  logic [31:0]  redirect_reg,
   output logic         halt,
   output logic         fault,
   output logic [31:0]  fault_pc
);

   // Highest PC from which a full word can still be fetched.
   localparam logic [31:0] LAST_FETCH_PC = 32'(MEM_BYTES - 4);

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic        out_valid_reg, out_valid_next;
   logic [31:0] out_instruction_reg, out_instruction_next;
   logic [31:0] out_pc_reg, out_pc_next;
   logic        halt_reg, halt_next;
   logic        fault_reg, fault_next;
   logic [31:0] fault_pc_reg, fault_pc_next;

   logic [31:0] redirect_target;
   logic        redirect_reserved;
   logic        pc_bad;
   logic        is_halt_op;

   redirect_target_calc u_target (
      .kind        (redirect_kind),
      .redirect_pc (redirect_pc),
      .imm16       (redirect_imm16),
      .jaddr       (redirect_jaddr),
      .reg_value   (redirect_reg),
      .target      (redirect_target),
      .reserved    (redirect_reserved)
   );

   assign pc_bad     = (pc_reg[1:0] != 2'b00) || (pc_reg > LAST_FETCH_PC);
   assign is_halt_op = (imem_instruction[OP_MSB:OP_LSB] == HALT_OPCODE);

   // State and fetch-register update; reset discards held and pending work.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg           <= ST_BOOT;
         pc_reg              <= RESET_PC;
         out_valid_reg       <= 1'b0;
         out_instruction_reg <= 32'h0;
         out_pc_reg          <= 32'h0;
         halt_reg            <= 1'b0;
         fault_reg           <= 1'b0;
         fault_pc_reg        <= 32'h0;
      end else begin
         state_reg           <= state_next;
         pc_reg              <= pc_next;
         out_valid_reg       <= out_valid_next;
         out_instruction_reg <= out_instruction_next;
         out_pc_reg          <= out_pc_next;
         halt_reg            <= halt_next;
         fault_reg           <= fault_next;
         fault_pc_reg        <= fault_pc_next;
      end
   end

   // Next-state: redirect beats load; a load either faults, halts or advances.
   always_comb begin
      state_next           = state_reg;
      pc_next              = pc_reg;
      out_valid_next       = out_valid_reg;
      out_instruction_next = out_instruction_reg;
      out_pc_next          = out_pc_reg;
      halt_next            = halt_reg;
      fault_next           = fault_reg;
      fault_pc_next        = fault_pc_reg;

      case (state_reg)
         ST_BOOT: begin
            if (start) begin
               state_next = ST_RUN;
            end
         end

         ST_RUN, ST_HALT: begin
            if (redirect_valid) begin
               out_valid_next = 1'b0;
               halt_next      = 1'b0;
               if (redirect_reserved) begin
                  state_next    = ST_FAULT;
                  fault_next    = 1'b1;
                  fault_pc_next = redirect_pc;
               end else begin
                  state_next = ST_RUN;
                  pc_next    = redirect_target;
               end
            end else if (state_reg == ST_HALT) begin
               // Parked: only drain the held instruction.
               if (out_ready) begin
                  out_valid_next = 1'b0;
               end
            end else if (!out_valid_reg || out_ready) begin
               if (pc_bad) begin
                  state_next     = ST_FAULT;
                  fault_next     = 1'b1;
                  fault_pc_next  = pc_reg;
                  out_valid_next = 1'b0;
               end else begin
                  out_instruction_next = imem_instruction;
                  out_pc_next          = pc_reg;
                  out_valid_next       = 1'b1;
                  if (is_halt_op) begin
                     state_next = ST_HALT;
                     halt_next  = 1'b1;
                  end else begin
                     pc_next = pc_reg + 32'd4;
                  end
               end
            end
         end

         default: begin
            // FAULT is sticky until reset.
         end
      endcase
   end

   assign imem_pc         = pc_reg;
   assign out_valid       = out_valid_reg;
   assign out_instruction = out_instruction_reg;
   assign out_pc          = out_pc_reg;
   assign halt            = halt_reg;
   assign fault           = fault_reg;
   assign fault_pc        = fault_pc_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a byte-array instruction memory model.
module tb_fetch_sequencer;

   logic         clk;
   logic         reset;
   logic         start;
   logic [31:0]  imem_pc;
   logic [31:0]  imem_instruction;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_instruction;
   logic [31:0]  out_pc;
   logic         redirect_valid;
   logic [1:0]   redirect_kind;
   logic [31:0]  redirect_pc;
   logic [15:0]  redirect_imm16;
   logic [25:0]  redirect_jaddr;
   logic [31:0]  redirect_reg;
   logic         halt;
   logic         fault;
   logic [31:0]  fault_pc;

   int checks;
   int errors;

   logic [7:0] mem [0:255];

   fetch_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .imem_pc          (imem_pc),
      .imem_instruction (imem_instruction),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instruction  (out_instruction),
      .out_pc           (out_pc),
      .redirect_valid   (redirect_valid),
      .redirect_kind    (redirect_kind),
      .redirect_pc      (redirect_pc),
      .redirect_imm16   (redirect_imm16),
      .redirect_jaddr   (redirect_jaddr),
      .redirect_reg     (redirect_reg),
      .halt             (halt),
      .fault            (fault),
      .fault_pc         (fault_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Big-endian combinational memory; out-of-range reads return zero.
   always_comb begin
      if (imem_pc <= 32'd252)
         imem_instruction = {mem[imem_pc[7:0]], mem[imem_pc[7:0] + 8'd1],
                             mem[imem_pc[7:0] + 8'd2], mem[imem_pc[7:0] + 8'd3]};
      else
         imem_instruction = 32'h0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_word(input int addr, input logic [31:0] w);
      mem[addr]     = w[31:24];
      mem[addr + 1] = w[23:16];
      mem[addr + 2] = w[15:8];
      mem[addr + 3] = w[7:0];
   endtask

   task automatic load_program();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      put_word(0,   32'h2001_0005);
      put_word(4,   32'h2002_0003);
      put_word(8,   32'h0022_1820);
      put_word(252, 32'h1234_5678);
   endtask

   task automatic clear_redirect();
      redirect_valid = 1'b0;
      redirect_kind  = 2'b00;
      redirect_pc    = 32'h0;
      redirect_imm16 = 16'h0;
      redirect_jaddr = 26'h0;
      redirect_reg   = 32'h0;
   endtask

   // Reset, then start: leaves the sequencer in RUN at RESET_PC with nothing held.
   task automatic reset_and_start();
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      clear_redirect();
      tick();
      reset = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; out_ready = 1'b1;
      clear_redirect();
      tick(); tick();
      reset = 1'b0;
      checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", imem_pc, 32'h0); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instruction); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
      checks++; if ({halt, fault} !== 2'b00) begin errors++; $display("FAIL reset_flags: got halt=%b fault=%b expected 0 0", halt, fault); end
      checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc: got %h expected 0", fault_pc); end
      // Without start, BOOT must not fetch.
      tick(); tick();
      checks++; if (out_valid !== 1'b0 || imem_pc !== 32'h0) begin errors++; $display("FAIL boot_idle: got valid=%b pc=%h expected 0 00000000", out_valid, imem_pc); end
      $display("test_reset done");
   endtask

   task automatic test_fetch();
      reset_and_start();
      out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fetch_first_cycle: got valid=%b expected 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== 32'h2001_0005) begin errors++; $display("FAIL fetch_0: got v=%b pc=%h ins=%h expected 1 00000000 20010005", out_valid, out_pc, out_instruction); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instruction !== 32'h2002_0003) begin errors++; $display("FAIL fetch_4: got v=%b pc=%h ins=%h expected 1 00000004 20020003", out_valid, out_pc, out_instruction); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instruction !== 32'h0022_1820) begin errors++; $display("FAIL fetch_8: got v=%b pc=%h ins=%h expected 1 00000008 00221820", out_valid, out_pc, out_instruction); end
      checks++; if (imem_pc !== 32'hC) begin errors++; $display("FAIL fetch_next_pc: got %h expected 0000000c", imem_pc); end
      $display("test_fetch done");
   endtask

   task automatic test_stall();
      reset_and_start();
      out_ready = 1'b1;
      tick(); tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instruction !== 32'h2002_0003 || imem_pc !== 32'h8) begin errors++; $display("FAIL stall_hold_%0d: got v=%b pc=%h ins=%h imem=%h expected 1 00000004 20020003 00000008", i, out_valid, out_pc, out_instruction, imem_pc); end
      end
      out_ready = 1'b1;
      tick();
      checks++; if (out_pc !== 32'h8 || out_instruction !== 32'h0022_1820 || imem_pc !== 32'hC) begin errors++; $display("FAIL stall_release: got pc=%h ins=%h imem=%h expected 00000008 00221820 0000000c", out_pc, out_instruction, imem_pc); end
      $display("test_stall done");
   endtask

   task automatic test_redirects();
      reset_and_start();
      out_ready = 1'b1;
      tick(); tick(); tick();
      // Branch from 0x08 back by two words: 0x08+4-8 = 0x04.
      redirect_valid = 1'b1; redirect_kind = 2'b00; redirect_pc = 32'h8; redirect_imm16 = 16'hFFFE;
      tick();
      clear_redirect();
      checks++; if (out_valid !== 1'b0 || imem_pc !== 32'h4) begin errors++; $display("FAIL branch_flush: got v=%b imem=%h expected 0 00000004", out_valid, imem_pc); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instruction !== 32'h2002_0003) begin errors++; $display("FAIL branch_fetch: got v=%b pc=%h ins=%h expected 1 00000004 20020003", out_valid, out_pc, out_instruction); end
      // Jump with a stalled instruction held: redirect flushes it anyway.
      out_ready = 1'b0;
      redirect_valid = 1'b1; redirect_kind = 2'b01; redirect_pc = 32'h10; redirect_jaddr = 26'h20;
      tick();
      clear_redirect();
      checks++; if (out_valid !== 1'b0 || imem_pc !== 32'h80) begin errors++; $display("FAIL jump_target: got v=%b imem=%h expected 0 00000080", out_valid, imem_pc); end
      // jr to a misaligned address faults on the following load attempt.
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_kind = 2'b10; redirect_reg = 32'h102;
      tick();
      clear_redirect();
      checks++; if (fault !== 1'b0 || imem_pc !== 32'h102) begin errors++; $display("FAIL jr_target: got fault=%b imem=%h expected 0 00000102", fault, imem_pc); end
      tick();
      checks++; if (fault !== 1'b1 || fault_pc !== 32'h102 || out_valid !== 1'b0) begin errors++; $display("FAIL jr_misaligned_fault: got fault=%b fpc=%h v=%b expected 1 00000102 0", fault, fault_pc, out_valid); end
      $display("test_redirects done");
   endtask

   task automatic test_boundary();
      reset_and_start();
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_kind = 2'b10; redirect_reg = 32'h100;
      tick();
      clear_redirect();
      tick();
      checks++; if (fault !== 1'b1 || fault_pc !== 32'h100) begin errors++; $display("FAIL jr_out_of_range: got fault=%b fpc=%h expected 1 00000100", fault, fault_pc); end
      // Last legal word at 0xFC loads; the increment to 0x100 then faults.
      reset_and_start();
      out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_kind = 2'b10; redirect_reg = 32'hFC;
      tick();
      clear_redirect();
      tick();
      checks++; if (fault !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'hFC || out_instruction !== 32'h1234_5678) begin errors++; $display("FAIL last_word: got fault=%b v=%b pc=%h ins=%h expected 0 1 000000fc 12345678", fault, out_valid, out_pc, out_instruction); end
      tick();
      checks++; if (fault !== 1'b1 || fault_pc !== 32'h100 || out_valid !== 1'b0) begin errors++; $display("FAIL past_end: got fault=%b fpc=%h v=%b expected 1 00000100 0", fault, fault_pc, out_valid); end
      $display("test_boundary done");
   endtask

   task automatic test_halt();
      put_word(12, 32'hFC00_0000);
      reset_and_start();
      out_ready = 1'b1;
      tick(); tick(); tick(); tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'hC || out_instruction !== 32'hFC00_0000 || halt !== 1'b1 || imem_pc !== 32'hC) begin errors++; $display("FAIL halt_load: got v=%b pc=%h ins=%h halt=%b imem=%h expected 1 0000000c fc000000 1 0000000c", out_valid, out_pc, out_instruction, halt, imem_pc); end
      tick(); tick();
      checks++; if (out_valid !== 1'b0 || halt !== 1'b1 || imem_pc !== 32'hC) begin errors++; $display("FAIL halt_parked: got v=%b halt=%b imem=%h expected 0 1 0000000c", out_valid, halt, imem_pc); end
      redirect_valid = 1'b1; redirect_kind = 2'b01; redirect_pc = 32'h10; redirect_jaddr = 26'h0;
      tick();
      clear_redirect();
      checks++; if (halt !== 1'b0 || imem_pc !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_resume: got halt=%b imem=%h v=%b expected 0 00000000 0", halt, imem_pc, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== 32'h2001_0005) begin errors++; $display("FAIL halt_refetch: got v=%b pc=%h ins=%h expected 1 00000000 20010005", out_valid, out_pc, out_instruction); end
      put_word(12, 32'h0);
      $display("test_halt done");
   endtask

   task automatic test_reserved();
      reset_and_start();
      out_ready = 1'b1;
      tick();
      redirect_valid = 1'b1; redirect_kind = 2'b11; redirect_pc = 32'h44;
      tick();
      checks++; if (fault !== 1'b1 || fault_pc !== 32'h44 || out_valid !== 1'b0) begin errors++; $display("FAIL rsvd_fault: got fault=%b fpc=%h v=%b expected 1 00000044 0", fault, fault_pc, out_valid); end
      redirect_kind = 2'b10; redirect_reg = 32'h20; start = 1'b1;
      tick(); tick();
      clear_redirect();
      start = 1'b0;
      checks++; if (fault !== 1'b1 || fault_pc !== 32'h44 || imem_pc !== 32'h4 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_sticky: got fault=%b fpc=%h imem=%h v=%b expected 1 00000044 00000004 0", fault, fault_pc, imem_pc, out_valid); end
      $display("test_reserved done");
   endtask

   task automatic test_reset_in_stall();
      reset_and_start();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; out_ready = 1'b1;
      checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instruction !== 32'h0 || imem_pc !== 32'h0 || halt !== 1'b0 || fault !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("FAIL stall_reset: got v=%b pc=%h ins=%h imem=%h halt=%b fault=%b fpc=%h expected all zero", out_valid, out_pc, out_instruction, imem_pc, halt, fault, fault_pc); end
      tick(); tick();
      checks++; if (out_valid !== 1'b0 || imem_pc !== 32'h0) begin errors++; $display("FAIL stall_reset_boot: got v=%b imem=%h expected 0 00000000", out_valid, imem_pc); end
      $display("test_reset_in_stall done");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      clear_redirect();
      load_program();
      test_reset();
      test_fetch();
      test_stall();
      test_redirects();
      test_boundary();
      test_halt();
      test_reserved();
      test_reset_in_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
